// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with valid/ready load and one-cycle done pulse
module countdown_timer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_value,
  input  logic         auto_reload,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [N-1:0]   reload_reg;
  logic           auto_reg;

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      auto_reg   <= 1'b0;
    end else if (abort) begin
      // abort also clears auto_reg so a pending reload from DONE is dropped
      state    <= IDLE;
      count    <= '0;
      auto_reg <= 1'b0;
    end else if (load_valid && state != RUN) begin
      reload_reg <= load_value;
      auto_reg   <= auto_reload;
      count      <= load_value;
      state      <= (load_value != '0) ? RUN : DONE;
    end else begin
      case (state)
        RUN: begin
          if (!pause) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              count <= '0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (auto_reg && reload_reg != '0) begin
            count <= reload_reg;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed vector bench for countdown_timer (N=8)
module tb_countdown_timer;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_value;
  logic         auto_reload;
  logic         pause;
  logic         abort;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  countdown_timer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       lv;
    logic [7:0] val;
    logic       ar;
    logic       pause;
    logic       abort;
    logic [7:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic lv, input logic [7:0] v,
                       input logic ar, input logic p, input logic ab);
    rst = r; load_valid = lv; load_value = v; auto_reload = ar; pause = p; abort = ab;
  endtask

  task automatic step_check(input string name, input logic [7:0] c, input logic b,
                            input logic d, input logic rdy);
    @(posedge clk);
    #1;
    chk({name, ".count"}, 32'(count), 32'(c));
    chk({name, ".busy"},  32'(busy),  32'(b));
    chk({name, ".done"},  32'(done),  32'(d));
    chk({name, ".ready"}, 32'(load_ready), 32'(rdy));
  endtask

  task automatic add(input string n, input logic r, input logic lv, input logic [7:0] v,
                     input logic ar, input logic p, input logic ab,
                     input logic [7:0] c, input logic b, input logic d, input logic rdy);
    vec_t x;
    x.name = n; x.rst = r; x.lv = lv; x.val = v; x.ar = ar; x.pause = p; x.abort = ab;
    x.exp_count = c; x.exp_busy = b; x.exp_done = d; x.exp_ready = rdy;
    vecs.push_back(x);
  endtask

  initial begin
    int k;
    checks = 0;
    failures = 0;
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    //  name          rst lv val ar p  ab   count busy done ready
    add("t1_rst0",     0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t1_rst1",     0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t2_load5",    1, 1, 5,  0, 0, 0,   5, 1, 0, 0);
    add("t2_c4",       1, 0, 0,  0, 0, 0,   4, 1, 0, 0);
    add("t2_c3",       1, 0, 0,  0, 0, 0,   3, 1, 0, 0);
    add("t2_c2",       1, 0, 0,  0, 0, 0,   2, 1, 0, 0);
    add("t2_c1",       1, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    add("t2_done",     1, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t2_idle",     1, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t3_load3",    1, 1, 3,  0, 0, 0,   3, 1, 0, 0);
    add("t3_p1",       1, 0, 0,  0, 1, 0,   3, 1, 0, 0);
    add("t3_p2",       1, 0, 0,  0, 1, 0,   3, 1, 0, 0);
    add("t3_c2",       1, 0, 0,  0, 0, 0,   2, 1, 0, 0);
    add("t3_c1",       1, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    add("t3_done",     1, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t3_idle",     1, 0, 0,  0, 1, 0,   0, 0, 0, 1);
    add("t3_load0",    1, 1, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t3_z_idle",   1, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t5_load9",    1, 1, 9,  0, 0, 0,   9, 1, 0, 0);
    add("t5_lv_run",   1, 1, 3,  0, 0, 0,   8, 1, 0, 0);
    add("t5_c7",       1, 0, 0,  0, 0, 0,   7, 1, 0, 0);
    add("t5_abort",    1, 0, 0,  0, 0, 1,   0, 0, 0, 1);
    add("t5_nodone",   1, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t5_ab_load",  1, 1, 4,  0, 0, 1,   0, 0, 0, 1);
    add("t5_ab_idle",  1, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t4_load1",    1, 1, 1,  0, 0, 0,   1, 1, 0, 0);
    add("t4_done",     1, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t4_b2b",      1, 1, 4,  0, 0, 0,   4, 1, 0, 0);
    add("t4_c3",       1, 0, 0,  0, 0, 0,   3, 1, 0, 0);
    add("t4_c2",       1, 0, 0,  0, 0, 0,   2, 1, 0, 0);
    add("t4_c1",       1, 0, 0,  0, 0, 0,   1, 1, 0, 0);
    add("t4_done2",    1, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t4_idle",     1, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    add("t5_ar_load1", 1, 1, 1,  1, 0, 0,   1, 1, 0, 0);
    add("t5_ar_done",  1, 0, 0,  0, 0, 0,   0, 0, 1, 1);
    add("t5_ab_done",  1, 0, 0,  0, 0, 1,   0, 0, 0, 1);
    add("t5_no_rel",   1, 0, 0,  0, 0, 0,   0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lv, vecs[i].val, vecs[i].ar, vecs[i].pause, vecs[i].abort);
      step_check(vecs[i].name, vecs[i].exp_count, vecs[i].exp_busy,
                 vecs[i].exp_done, vecs[i].exp_ready);
    end

    // auto-reload of 2: pattern 2,1,0(done) repeating, period 3, four periods
    drive(1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 12; p++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk("t4_auto.count", 32'(count), 32'(2 - (p % 3)));
      chk("t4_auto.done",  32'(done),  32'((p % 3) == 2));
    end
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step_check("t4_auto_stop", 8'd0, 1'b0, 1'b0, 1'b1);

    // full-range load: count 255 down to 0 with no wrap, done after 255 decrements
    drive(1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    k = 0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    while (!done && k < 400) begin
      chk("t6_full.count", 32'(count), 32'(255 - k));
      k++;
      @(posedge clk);
      #1;
    end
    chk("t6_full.done_at", 32'(k), 32'd255);
    chk("t6_full.zero", 32'(count), 32'd0);
    step_check("t6_full_idle", 8'd0, 1'b0, 1'b0, 1'b1);

    // reset while in DONE with auto-reload armed
    drive(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    step_check("t6_r_load", 8'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step_check("t6_r_c2", 8'd2, 1'b1, 1'b0, 1'b0);
    step_check("t6_r_c1", 8'd1, 1'b1, 1'b0, 1'b0);
    step_check("t6_r_done", 8'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step_check("t6_r_rst", 8'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step_check("t6_r_norel", 8'd0, 1'b0, 1'b0, 1'b1);
    step_check("t6_r_norel2", 8'd0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
